// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- sequencing and hazard controller for the 5-stage pipeline.
//
// Holds the pipeline in a start-up flush after reset. It then decodes load-use
// hazards, taken branches and data-memory stalls into load enables, flushes and
// bubbles. A memory access that never completes locks the pipe in a sticky
// fault that only reset clears.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ID_EX_mem_read/_rt  load in EX and its destination register
//   IF_ID_rs/_rt        source fields of the instruction in ID
//   EX_branch_taken     branch resolved taken in EX
//   MEM_mem_read/_write MEM stage memory access, mem_ready = access completes
//   startin             synchronous clear to all pipeline registers
//   pc_write            PC load enable
//   IF_ID_write         IF/ID load enable
//   IF_ID_flush         zero IF/ID
//   ID_EX_bubble        zero the ID/EX control fields
//   pipe_hold           hold ID/EX, EX/MEM and MEM/WB
//   stall_count         saturating count of cycles with pc_write low (after INIT)
//   mem_error           sticky memory-timeout fault
module pipeline_ctrl #(
  parameter int INIT_FLUSH_CYCLES = 4,
  parameter int MEM_TIMEOUT       = 15,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ID_EX_mem_read,
  input  logic [4:0]             ID_EX_rt,
  input  logic [4:0]             IF_ID_rs,
  input  logic [4:0]             IF_ID_rt,
  input  logic                   EX_branch_taken,
  input  logic                   MEM_mem_read,
  input  logic                   MEM_mem_write,
  input  logic                   mem_ready,
  output logic                   startin,
  output logic                   pc_write,
  output logic                   IF_ID_write,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_bubble,
  output logic                   pipe_hold,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   mem_error
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_MEM_WAIT, ST_FAULT} state_t;

  localparam logic [7:0]             INIT_LAST  = 8'(INIT_FLUSH_CYCLES - 1);
  localparam logic [7:0]             WAIT_LIMIT = 8'(MEM_TIMEOUT);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [7:0]             init_cnt_q, init_cnt_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   mem_error_q, mem_error_d;

  logic mem_busy;
  logic load_use;

  assign mem_busy = (MEM_mem_read | MEM_mem_write) & ~mem_ready;
  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = ID_EX_mem_read & (ID_EX_rt != 5'd0) &
                    ((ID_EX_rt == IF_ID_rs) | (ID_EX_rt == IF_ID_rt));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= 8'd0;
      wait_cnt_q    <= 8'd0;
      stall_count_q <= '0;
      mem_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      mem_error_q   <= mem_error_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_error_d   = mem_error_q;
    stall_count_d = stall_count_q;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = 8'd0;
        end else begin
          init_cnt_d = init_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        // The cycle that discovers the busy memory already counts as wait 1.
        if (mem_busy) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LIMIT) begin
            state_d     = ST_FAULT;
            mem_error_d = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        mem_error_d = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Any post-flush cycle that does not advance the PC counts as a stall.
    if ((state_q != ST_INIT) && !pc_write && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + STALL_ONE;
    end
  end

  // Output decode (Mealy on the hazard inputs)
  always_comb begin
    startin      = 1'b0;
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_hold    = 1'b0;

    case (state_q)
      ST_INIT: begin
        startin = 1'b1;
      end
      ST_RUN, ST_MEM_WAIT: begin
        // While waiting, only mem_ready releases the freeze; the access
        // request lines are not re-examined.
        if ((state_q == ST_RUN) ? mem_busy : ~mem_ready) begin
          pipe_hold = 1'b1;
        end else if (EX_branch_taken) begin
          // The ID instruction is wrong-path, so a load-use hit on it is moot.
          pc_write     = 1'b1;
          IF_ID_write  = 1'b1;
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else if (load_use) begin
          ID_EX_bubble = 1'b1;
        end else begin
          pc_write    = 1'b1;
          IF_ID_write = 1'b1;
        end
      end
      ST_FAULT: begin
        pipe_hold = 1'b1;
      end
      default: begin
        startin = 1'b1;
      end
    endcase
  end

  assign stall_count = stall_count_q;
  assign mem_error   = mem_error_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl. The driver applies one input set per
// cycle, predicts the outputs from a cycle-level model of the controller's
// rules and queues the prediction. The monitor pops and compares at each
// falling edge.
module tb_pipeline_ctrl;

  localparam int INIT_N  = 4;
  localparam int TIMEOUT = 15;
  localparam int CW      = 6;   // narrow counter so saturation is reached quickly
  localparam int CMAX    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_ex_mem_read;
  logic [4:0]    id_ex_rt;
  logic [4:0]    if_id_rs;
  logic [4:0]    if_id_rt;
  logic          ex_branch_taken;
  logic          mem_mem_read;
  logic          mem_mem_write;
  logic          mem_ready;
  logic          startin;
  logic          pc_write;
  logic          if_id_write;
  logic          if_id_flush;
  logic          id_ex_bubble;
  logic          pipe_hold;
  logic [CW-1:0] stall_count;
  logic          mem_error;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .INIT_FLUSH_CYCLES(INIT_N),
    .MEM_TIMEOUT      (TIMEOUT),
    .STALL_CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_EX_mem_read (id_ex_mem_read),
    .ID_EX_rt       (id_ex_rt),
    .IF_ID_rs       (if_id_rs),
    .IF_ID_rt       (if_id_rt),
    .EX_branch_taken(ex_branch_taken),
    .MEM_mem_read   (mem_mem_read),
    .MEM_mem_write  (mem_mem_write),
    .mem_ready      (mem_ready),
    .startin        (startin),
    .pc_write       (pc_write),
    .IF_ID_write    (if_id_write),
    .IF_ID_flush    (if_id_flush),
    .ID_EX_bubble   (id_ex_bubble),
    .pipe_hold      (pipe_hold),
    .stall_count    (stall_count),
    .mem_error      (mem_error)
  );

  typedef struct packed {
    logic          startin;
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_bubble;
    logic          pipe_hold;
    logic [CW-1:0] stall_count;
    logic          mem_error;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state, in terms of observable behaviour only.
  int since_reset = 0;  // cycles run since reset released
  bit freezing    = 0;  // a memory access is currently holding the pipe
  int wait_cycles = 0;  // not-ready cycles spent after the freeze began
  bit faulted     = 0;
  bit err_m       = 0;
  int stalls      = 0;

  function automatic void model_reset();
    since_reset = 0;
    freezing    = 0;
    wait_cycles = 0;
    faulted     = 0;
    err_m       = 0;
    stalls      = 0;
  endfunction

  task automatic step(input bit rst, input bit mr, input logic [4:0] exrt,
                      input logic [4:0] rs, input logic [4:0] rt, input bit br,
                      input bit mrd, input bit mwr, input bit rdy);
    obs_t e;
    bit   busy;
    bit   lu;
    @(posedge clk);
    #1;
    rst_n           = rst;
    id_ex_mem_read  = mr;
    id_ex_rt        = exrt;
    if_id_rs        = rs;
    if_id_rt        = rt;
    ex_branch_taken = br;
    mem_mem_read    = mrd;
    mem_mem_write   = mwr;
    mem_ready       = rdy;

    e = '0;
    if (!rst) begin
      model_reset();
      e.startin = 1'b1;
    end else begin
      e.stall_count = stalls[CW-1:0];
      e.mem_error   = err_m;
      if (since_reset < INIT_N) begin
        e.startin = 1'b1;
        since_reset++;
      end else begin
        if (faulted) begin
          e.pipe_hold = 1'b1;
        end else begin
          busy = freezing ? !rdy : ((mrd | mwr) && !rdy);
          if (busy) begin
            e.pipe_hold = 1'b1;
            if (freezing) begin
              wait_cycles++;
              if (wait_cycles == TIMEOUT) begin
                faulted = 1;
                err_m   = 1;
              end
            end else begin
              freezing    = 1;
              wait_cycles = 0;
            end
          end else begin
            freezing = 0;
            lu = mr && (exrt != 0) && (exrt == rs || exrt == rt);
            if (br) begin
              e.pc_write     = 1'b1;
              e.if_id_write  = 1'b1;
              e.if_id_flush  = 1'b1;
              e.id_ex_bubble = 1'b1;
            end else if (lu) begin
              e.id_ex_bubble = 1'b1;
            end else begin
              e.pc_write    = 1'b1;
              e.if_id_write = 1'b1;
            end
          end
        end
        if (!e.pc_write && stalls < CMAX) stalls++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Reset asserted between clock edges must take effect before the next edge.
  task automatic async_reset();
    obs_t e;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (!(startin === 1'b1 && pc_write === 1'b0 && if_id_write === 1'b0 &&
          if_id_flush === 1'b0 && id_ex_bubble === 1'b0 && pipe_hold === 1'b0 &&
          stall_count === '0 && mem_error === 1'b0)) begin
      miscompares++;
      $display("FAIL async_reset: got startin=%b pc_write=%b hold=%b stall=%0d err=%b, want startin=1 pc_write=0 hold=0 stall=0 err=0",
               startin, pc_write, pipe_hold, stall_count, mem_error);
    end else begin
      $display("t=%0t async_reset ok", $time);
    end
    model_reset();
    e = '0;
    e.startin = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{startin, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
            stall_count, mem_error};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got st=%b pcw=%b ifw=%b fl=%b bb=%b hold=%b cnt=%0d err=%b, want st=%b pcw=%b ifw=%b fl=%b bb=%b hold=%b cnt=%0d err=%b",
                 $time, a.startin, a.pc_write, a.if_id_write, a.if_id_flush,
                 a.id_ex_bubble, a.pipe_hold, a.stall_count, a.mem_error,
                 e.startin, e.pc_write, e.if_id_write, e.if_id_flush,
                 e.id_ex_bubble, e.pipe_hold, e.stall_count, e.mem_error);
      end else begin
        $display("t=%0t rst_n=%b st=%b pcw=%b ifw=%b fl=%b bb=%b hold=%b cnt=%0d err=%b ok",
                 $time, rst_n, a.startin, a.pc_write, a.if_id_write, a.if_id_flush,
                 a.id_ex_bubble, a.pipe_hold, a.stall_count, a.mem_error);
      end
    end
  end

  initial begin
    int starve;
    int rst_left;
    rst_n           = 1'b0;
    id_ex_mem_read  = 1'b0;
    id_ex_rt        = 5'd0;
    if_id_rs        = 5'd0;
    if_id_rt        = 5'd0;
    ex_branch_taken = 1'b0;
    mem_mem_read    = 1'b0;
    mem_mem_write   = 1'b0;
    mem_ready       = 1'b1;

    // Reset, start-up flush, then normal running.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(INIT_N + 2);

    // Load-use stall, then the same load to register 0 (no stall).
    step(1, 1, 5'd5, 5'd5, 5'd1, 0, 0, 0, 1);
    idle(1);
    step(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    step(1, 1, 5'd7, 5'd2, 5'd7, 0, 0, 0, 1);   // hit on rt field
    // Branch together with load-use: branch wins, no stall counted.
    step(1, 1, 5'd5, 5'd5, 5'd1, 1, 0, 0, 1);
    idle(1);

    // Load with three not-ready cycles, released on the ready cycle.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 1);   // release straight into load-use
    idle(2);

    // Store that never completes: timeout into fault, then reset clears it.
    for (int i = 0; i < TIMEOUT + 6; i++) step(1, 0, 0, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(INIT_N + 2);

    // Reset asserted asynchronously while frozen on memory.
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    async_reset();
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(INIT_N + 1);

    // Randomised traffic with occasional memory starvation and resets.
    starve   = 0;
    rst_left = 0;
    for (int i = 0; i < 1500; i++) begin
      bit rdy;
      bit rst;
      if (starve == 0 && $urandom_range(0, 79) == 0) starve = $urandom_range(5, 24);
      if (rst_left == 0 && $urandom_range(0, 249) == 0) rst_left = $urandom_range(1, 3);
      rdy = (starve > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      rst = (rst_left == 0);
      if (starve > 0) starve--;
      if (rst_left > 0) rst_left--;
      step(rst,
           ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0),
           rdy);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencing/hazard controller for the 5-stage pipeline.
- Owns the start-up flush: drives `startin` into the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Issues load-use stalls, taken-branch flushes and whole-pipeline freezes while the data memory is busy.
- Counts stall cycles and latches a fault if a memory access times out.

Parameters:
- INIT_FLUSH_CYCLES, 4: cycles `startin` is held high after reset release; legal range 1..255.
- MEM_TIMEOUT, 15: maximum cycles spent in MEM_WAIT before fault; legal range 1..255.
- STALL_CNT_W, 16: width of `stall_count`.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_EX_mem_read  in  1  instruction in EX is a load.
- ID_EX_rt  in  5  destination register of that load.
- IF_ID_rs  in  5  rs field of the instruction in ID.
- IF_ID_rt  in  5  rt field of the instruction in ID.
- EX_branch_taken  in  1  branch resolved taken in EX this cycle.
- MEM_mem_read  in  1  MEM stage is performing a load.
- MEM_mem_write  in  1  MEM stage is performing a store.
- mem_ready  in  1  data memory completes the access this cycle.
- startin  out  1  synchronous clear to all pipeline registers.
- pc_write  out  1  PC load enable.
- IF_ID_write  out  1  IF/ID load enable.
- IF_ID_flush  out  1  zero IF/ID this cycle.
- ID_EX_bubble  out  1  force ID/EX control fields (wb, m, ex) to zero.
- pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB (no load).
- stall_count  out  STALL_CNT_W  saturating count of stalled cycles.
- mem_error  out  1  sticky memory-timeout fault.

Behaviour:
- States: INIT, RUN, MEM_WAIT, FAULT. 8-bit `init_cnt` and `wait_cnt`.
- Async reset (rst_n=0): state=INIT, init_cnt=0, wait_cnt=0, stall_count=0, mem_error=0.
  - Outputs during reset: startin=1, pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0, pipe_hold=0.
  - Reset asserted mid-operation (any state) returns to INIT immediately. No partial state survives.
- INIT:
  - startin=1, pc_write=0, IF_ID_write=0, all other control outputs 0.
  - init_cnt increments each cycle. When init_cnt==INIT_FLUSH_CYCLES-1, next state is RUN.
  - startin is therefore high for exactly INIT_FLUSH_CYCLES rising edges after rst_n deasserts.
- Definitions used below (combinational, same cycle, Mealy decode):
  - mem_busy = (MEM_mem_read|MEM_mem_write) & ~mem_ready.
  - load_use = ID_EX_mem_read & ID_EX_rt!=0 & (ID_EX_rt==IF_ID_rs | ID_EX_rt==IF_ID_rt).
- RUN, priority mem_busy > EX_branch_taken > load_use > normal:
  - mem_busy: pc_write=0, IF_ID_write=0, pipe_hold=1, flush=0, bubble=0. Next state MEM_WAIT, wait_cnt=1.
  - EX_branch_taken: pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1. Branch wins over a simultaneous load_use because the ID instruction is wrong-path.
  - load_use: pc_write=0, IF_ID_write=0, ID_EX_bubble=1. One-cycle stall; re-evaluated next cycle.
  - normal: pc_write=1, IF_ID_write=1, all others 0.
- MEM_WAIT:
  - mem_ready=0: outputs identical to the mem_busy case; wait_cnt increments.
    - If wait_cnt==MEM_TIMEOUT, next state is FAULT and mem_error<=1.
  - mem_ready=1: freeze released this cycle. Outputs follow the RUN priority with mem_busy treated as 0. Next state RUN, wait_cnt=0.
  - EX_branch_taken or load_use during a freeze is ignored. Inputs are held stable by the freeze, so they are re-evaluated on release.
- FAULT:
  - pc_write=0, IF_ID_write=0, pipe_hold=1, mem_error=1.
  - Leaves only via rst_n.
- stall_count: +1 on every cycle in RUN/MEM_WAIT/FAULT where pc_write=0. Saturates at all-ones. INIT cycles are not counted.
- startin=0 in every state except INIT.

Test Plan:
- Reset release with INIT_FLUSH_CYCLES=4 → startin high exactly 4 edges, then pc_write=1; stall_count=0.
- Load-use hazard: ID_EX_mem_read=1, ID_EX_rt=5, IF_ID_rs=5 → one cycle with pc_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_count=1. Repeat with ID_EX_rt=0 → no stall.
- Load-use and EX_branch_taken in the same cycle → IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; stall_count unchanged.
- MEM_mem_read=1, mem_ready low for 3 cycles then high → pipe_hold=1 for 3 cycles, released on the ready cycle; stall_count=3; no mem_error.
- mem_ready held low with MEM_TIMEOUT=15 → FAULT entered, mem_error=1, pipe_hold stuck at 1. rst_n pulse → INIT, mem_error=0.
- rst_n asserted mid-MEM_WAIT → outputs immediately take reset values (startin=1) without waiting for a clock edge.
